// File: rtl/led_pkg.sv
// ============================================================================
//  Module   : led_pkg
//  Brief    : Shared mode encodings and constants for the LED chaser.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package led_pkg;

    // Pattern-select encoding carried on the mode input
    typedef logic [1:0] mode_t;

    localparam mode_t MODE_UP    = 2'b00;
    localparam mode_t MODE_DOWN  = 2'b01;
    localparam mode_t MODE_PING  = 2'b10;
    localparam mode_t MODE_BLINK = 2'b11;

    // Ping-pong travel direction
    localparam logic c_DIR_UP   = 1'b0;
    localparam logic c_DIR_DOWN = 1'b1;

endpackage : led_pkg

`default_nettype wire

// File: rtl/led_step_timer.sv
// ============================================================================
//  Module   : led_step_timer
//  Brief    : Enable-gated period counter; flags the last cycle of each step
//             period so the chaser can advance on the following edge.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_step_timer #(
    parameter int STEP_CYCLES = 50_000_000,
    parameter int CNT_W       = 32
) (
    input  logic clk,
    input  logic rest,
    input  logic en,
    output logic tick
);

    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(STEP_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_ONE  = CNT_W'(1);

    // Reject parameter sets the counter cannot represent
    generate
        if (STEP_CYCLES < 2) begin : g_bad_step_cycles
            $error("led_step_timer: STEP_CYCLES must be 2 or more");
        end
        if ((CNT_W < 63) &&
            ((64'(STEP_CYCLES) - 64'd1) >= (64'd1 << CNT_W))) begin : g_bad_cnt_w
            $error("led_step_timer: STEP_CYCLES-1 does not fit in CNT_W bits");
        end
    endgenerate

    logic [CNT_W-1:0] r_cnt;

    // Count 0..STEP_CYCLES-1 while enabled, hold while disabled
    always_ff @(posedge clk) begin
        if (rest) begin
            r_cnt <= '0;
        end else if (en) begin
            if (r_cnt == c_LAST) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + c_ONE;
            end
        end
    end

    assign tick = en && (r_cnt == c_LAST);

endmodule : led_step_timer

`default_nettype wire

// File: rtl/led_chaser.sv
// ============================================================================
//  Module   : led_chaser
//  Brief    : Active-low LED pattern generator (rotate up/down, ping-pong,
//             blink-all) advancing once per STEP_CYCLES enabled cycles.
//             Optional macro LED_CHASER_PWM_EN dims lit LEDs with a
//             free-running 4-bit PWM gated by parameter DUTY.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_chaser
    import led_pkg::*;
#(
    parameter int N_LED       = 4,
    parameter int STEP_CYCLES = 50_000_000,
    parameter int CNT_W       = 32
`ifdef LED_CHASER_PWM_EN
    ,
    parameter int DUTY        = 8
`endif
) (
    input  logic             clk,
    input  logic             rest,
    input  logic             en,
    input  logic [1:0]       mode,
    output logic [N_LED-1:0] ledn,
    output logic             step
);

    localparam int                c_POS_W    = (N_LED > 1) ? $clog2(N_LED) : 1;
    localparam logic [c_POS_W-1:0] c_LAST_POS = c_POS_W'(N_LED - 1);
    localparam logic [c_POS_W-1:0] c_ONE_POS  = c_POS_W'(1);

    generate
        if (N_LED < 1 || N_LED > 32) begin : g_bad_n_led
            $error("led_chaser: N_LED must be in 1..32");
        end
    endgenerate

    logic               w_tick;
    mode_t              w_mode;

    logic [c_POS_W-1:0] r_pos;
    logic               r_dir;
    logic               r_ph;
    logic               r_started;
    logic [N_LED-1:0]   r_lit;

    logic [c_POS_W-1:0] w_pos_nx;
    logic               w_dir_nx;
    logic               w_ph_nx;
    logic               w_started_nx;
    logic [N_LED-1:0]   w_lit_nx;
    logic [N_LED-1:0]   w_drive;

    assign w_mode = mode;

    led_step_timer #(
        .STEP_CYCLES (STEP_CYCLES),
        .CNT_W       (CNT_W)
    ) u_timer (
        .clk  (clk),
        .rest (rest),
        .en   (en),
        .tick (w_tick)
    );

    // Next position/direction/phase and lit pattern; mode is looked at only on a tick
    always_comb begin
        w_pos_nx     = r_pos;
        w_dir_nx     = r_dir;
        w_ph_nx      = r_ph;
        w_started_nx = r_started;
        w_lit_nx     = r_lit;
        if (w_tick) begin
            w_started_nx = 1'b1;
            if (!r_started) begin
                // First step after reset always lands on LED 0 going up
                w_pos_nx = '0;
                w_dir_nx = c_DIR_UP;
                w_ph_nx  = (w_mode == MODE_BLINK);
            end else begin
                case (w_mode)
                    MODE_UP: begin
                        w_pos_nx = (r_pos == c_LAST_POS) ? '0 : r_pos + c_ONE_POS;
                    end
                    MODE_DOWN: begin
                        w_pos_nx = (r_pos == '0) ? c_LAST_POS : r_pos - c_ONE_POS;
                    end
                    MODE_PING: begin
                        // A single LED has nowhere to bounce: hold pos and dir
                        if (N_LED > 1) begin
                            if (r_dir == c_DIR_UP) begin
                                if (r_pos == c_LAST_POS) begin
                                    w_dir_nx = c_DIR_DOWN;
                                    w_pos_nx = r_pos - c_ONE_POS;
                                end else begin
                                    w_pos_nx = r_pos + c_ONE_POS;
                                end
                            end else begin
                                if (r_pos == '0) begin
                                    w_dir_nx = c_DIR_UP;
                                    w_pos_nx = c_ONE_POS;
                                end else begin
                                    w_pos_nx = r_pos - c_ONE_POS;
                                end
                            end
                        end
                    end
                    default: begin
                        // Phase is parked at 0 outside blink, so entry toggles it to 1
                        w_ph_nx = ~r_ph;
                    end
                endcase
                if (w_mode != MODE_BLINK) begin
                    w_ph_nx = 1'b0;
                end
            end
            if (w_mode == MODE_BLINK) begin
                w_lit_nx = w_ph_nx ? '1 : '0;
            end else begin
                w_lit_nx = N_LED'(1) << w_pos_nx;
            end
        end
    end

`ifdef LED_CHASER_PWM_EN
    logic [3:0] r_pwm;
    logic       w_pwm_on;

    // Free-running PWM slot counter
    always_ff @(posedge clk) begin
        if (rest) begin
            r_pwm <= 4'd0;
        end else begin
            r_pwm <= r_pwm + 4'd1;
        end
    end

    assign w_pwm_on = (r_pwm < 4'(DUTY));
    assign w_drive  = w_lit_nx & {N_LED{w_pwm_on}};
`else
    assign w_drive  = w_lit_nx;
`endif

    // Pattern state and registered active-low outputs
    always_ff @(posedge clk) begin
        if (rest) begin
            r_pos     <= '0;
            r_dir     <= c_DIR_UP;
            r_ph      <= 1'b0;
            r_started <= 1'b0;
            r_lit     <= '0;
            ledn      <= '1;
            step      <= 1'b0;
        end else begin
            r_pos     <= w_pos_nx;
            r_dir     <= w_dir_nx;
            r_ph      <= w_ph_nx;
            r_started <= w_started_nx;
            r_lit     <= w_lit_nx;
            ledn      <= ~w_drive;
            step      <= w_tick;
        end
    end

endmodule : led_chaser

`default_nettype wire

// File: doc/led_chaser.md
LED_CHASER -- requirements
Module: led_chaser

Interface
REQ-001 SHALL have parameter N_LED, default 4, number of LED outputs (legal range 1..32).
REQ-002 SHALL have parameter STEP_CYCLES, default 50_000_000, clock cycles per pattern step (legal range 2 or more).
REQ-003 SHALL have parameter CNT_W, default 32, step-timer width; STEP_CYCLES-1 SHALL fit in CNT_W bits (elaboration error otherwise).
REQ-004 Port: clk, input, 1, sole clock; all logic on its rising edge.
REQ-005 Port: rest, input, 1, reset; synchronous, active-high.
REQ-006 Port: en, input, 1, run enable; 0 freezes timer and pattern.
REQ-007 Port: mode, input, 2, pattern select: 00 rotate-up, 01 rotate-down, 10 ping-pong, 11 blink-all.
REQ-008 Port: ledn, output, N_LED, LED drive, active-low (0 = lit), registered.
REQ-009 Port: step, output, 1, one-cycle pulse marking each pattern advance, registered.

Function
REQ-010 Timer SHALL count 0..STEP_CYCLES-1 while en=1, then wrap to 0; it holds its value while en=0.
REQ-011 A step event SHALL occur on the cycle the timer equals STEP_CYCLES-1 and en=1; ledn and step SHALL update on the following edge (1-cycle latency).
REQ-012 step SHALL be 1 for exactly one cycle per step event, else 0.
REQ-013 The block SHALL hold position pos (0..N_LED-1), direction dir (up/down), blink phase ph, and flag started; mode SHALL be sampled only at step events.
REQ-014 First step after reset: pos=0, dir=up, started=1, ledn = only bit 0 low; mode 11 instead gives ph=1, all bits low.
REQ-015 Rotate-up: pos <= pos+1, wrapping N_LED-1 to 0.
REQ-016 Rotate-down: pos <= pos-1, wrapping 0 to N_LED-1.
REQ-017 Ping-pong: move pos one toward dir; at pos=N_LED-1 with dir=up, dir <= down and pos <= N_LED-2; at pos=0 with dir=down, dir <= up and pos <= 1.
REQ-018 Ping-pong with N_LED=1: pos stays 0 and dir is unchanged.
REQ-019 Rotate and ping-pong: ledn = all ones except bit pos = 0.
REQ-020 Blink-all: ph toggles each step; ledn = all zeros when ph=1, all ones when ph=0; pos and dir SHALL be held.
REQ-021 Entering blink-all from another mode SHALL set ph=1 on that step.
REQ-022 Leaving blink-all SHALL resume from the held pos/dir, applying the new mode's rule on that step.
REQ-023 Mode changes between step events SHALL have no visible effect until the next step event.
REQ-024 Deasserting en mid-period SHALL keep timer, ledn and pos; reasserting it resumes the count with no lost or extra step.

Reset
REQ-025 While rest=1 at a clock edge: timer=0, pos=0, dir=up, ph=0, started=0, ledn=all ones, step=0.
REQ-026 Reset SHALL take priority over en and over any step event on the same edge.
REQ-027 Reset asserted mid-period SHALL discard the partial count; the first step comes STEP_CYCLES enabled cycles after reset release.

Configuration
REQ-028 Macro LED_CHASER_PWM_EN defined: each lit LED SHALL be gated by a free-running 4-bit PWM counter.
REQ-029 With LED_CHASER_PWM_EN, a lit bit is driven low only while pwm_cnt < DUTY (parameter, default 8, range 0..15, 0 = always dark); unlit bits stay high.
REQ-030 Without LED_CHASER_PWM_EN: no PWM logic and no DUTY parameter; lit bits are steadily low.

Structure
REQ-031 Package led_pkg SHALL hold the mode encodings (MODE_UP, MODE_DOWN, MODE_PING, MODE_BLINK) and the 2-bit mode typedef.
REQ-032 Sub-module led_step_timer (parameters STEP_CYCLES, CNT_W; ports clk, rest, en, tick) SHALL implement REQ-010 and REQ-011; led_chaser instantiates it once.

Verification (N_LED=4, STEP_CYCLES=4 unless noted)
REQ-033 rest 1 then 0, en=1, mode=00 -> ledn 1111 for 4 cycles, then 1110, 1101, 1011, 0111, 1110 every 4 cycles; step pulses once per change.
REQ-034 mode=10 from reset -> pos sequence 0,1,2,3,2,1,0,1; ledn 1110,1101,1011,0111,1011,1101,1110,1101.
REQ-035 mode=01 after first step -> ledn 1110 then 0111, 1011; mode toggled 00/01 mid-period -> only the value at the step edge matters.
REQ-036 mode=11 at pos=2 -> ledn 0000, 1111, 0000; then mode=00 -> ledn 0111 (pos=3).
REQ-037 en=0 for 10 cycles mid-period, and rest=1 pulsed mid-period -> ledn and timer frozen during en=0; after reset, ledn=1111 and the first step comes exactly 4 cycles after release.
REQ-038 N_LED=1, mode=10 -> ledn stays 0 after the first step; LED_CHASER_PWM_EN with DUTY=4 -> the lit bit is low 4 of every 16 cycles.
